// File: rtl/gameover_banner_if.sv
// Pixel bus between the scan generator and the GAME OVER banner controller:
// the scan coordinates going in and the rectangle hit/offset coming back.
interface gameover_banner_if;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        InsideRectangle;
  logic [10:0] offsetX;
  logic [10:0] offsetY;

  modport master (
    output pixelX, pixelY,
    input  InsideRectangle, offsetX, offsetY
  );

  modport slave (
    input  pixelX, pixelY,
    output InsideRectangle, offsetX, offsetY
  );
endinterface

// File: rtl/gameover_banner_ctrl.sv
// GAME OVER banner position/animation: slides down, blinks, then holds, and
// produces the registered per-pixel hit/offset triple for the bitmap block.
module gameover_banner_ctrl #(
  parameter int OBJECT_WIDTH_X  = 140,
  parameter int OBJECT_HEIGHT_Y = 24,
  parameter int FINAL_X         = 250,
  parameter int FINAL_Y         = 228,
  parameter int START_Y         = 0,
  parameter int SLIDE_STEP      = 4,
  parameter int BLINK_FRAMES    = 16,
  parameter int BLINK_COUNT     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame_i,
  input  logic               gameOverTrig_i,
  input  logic               restartReq_i,
  output logic               bannerActive_o,
  output logic               animDone_o,
  gameover_banner_if.slave   pix
);

  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int BC_W = $clog2(BLINK_COUNT + 1);

  typedef enum logic [1:0] {IDLE, SLIDE, BLINK, HOLD} state_t;

  state_t            state_q, state_d;
  logic [10:0]       topY_q, topY_d;
  logic              visible_q, visible_d;
  logic [FC_W-1:0]   frameCnt_q, frameCnt_d;
  logic [BC_W-1:0]   blinkCnt_q, blinkCnt_d;

  logic [11:0]       slide_sum;
  logic [11:0]       px12, py12, top12;
  logic              hit;

  logic              inside_q;
  logic [10:0]       offX_q, offY_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      topY_q     <= 11'(START_Y);
      visible_q  <= 1'b0;
      frameCnt_q <= '0;
      blinkCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      topY_q     <= topY_d;
      visible_q  <= visible_d;
      frameCnt_q <= frameCnt_d;
      blinkCnt_q <= blinkCnt_d;
    end
  end

  assign slide_sum = {1'b0, topY_q} + 12'(SLIDE_STEP);

  always_comb begin
    state_d    = state_q;
    topY_d     = topY_q;
    visible_d  = visible_q;
    frameCnt_d = frameCnt_q;
    blinkCnt_d = blinkCnt_q;
    if (restartReq_i) begin
      state_d    = IDLE;
      topY_d     = 11'(START_Y);
      visible_d  = 1'b0;
      frameCnt_d = '0;
      blinkCnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gameOverTrig_i) begin
            state_d   = SLIDE;
            topY_d    = 11'(START_Y);
            visible_d = 1'b1;
          end
        end
        SLIDE: begin
          if (startOfFrame_i) begin
            // Clamp the final step so the banner never overshoots its rest row.
            if (slide_sum >= 12'(FINAL_Y)) begin
              topY_d     = 11'(FINAL_Y);
              state_d    = BLINK;
              frameCnt_d = '0;
              blinkCnt_d = '0;
            end else begin
              topY_d = slide_sum[10:0];
            end
          end
        end
        BLINK: begin
          if (startOfFrame_i) begin
            if (frameCnt_q == FC_W'(BLINK_FRAMES - 1)) begin
              frameCnt_d = '0;
              visible_d  = ~visible_q;
              if (!visible_q) begin
                blinkCnt_d = blinkCnt_q + BC_W'(1);
                if (blinkCnt_q == BC_W'(BLINK_COUNT - 1)) state_d = HOLD;
              end
            end else begin
              frameCnt_d = frameCnt_q + FC_W'(1);
            end
          end
        end
        HOLD: begin
          visible_d = 1'b1;
          topY_d    = 11'(FINAL_Y);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // 12-bit compares so topY+height cannot wrap.
  assign px12  = {1'b0, pix.pixelX};
  assign py12  = {1'b0, pix.pixelY};
  assign top12 = {1'b0, topY_q};
  assign hit   = visible_q
              && (px12 >= 12'(FINAL_X)) && (px12 < 12'(FINAL_X + OBJECT_WIDTH_X))
              && (py12 >= top12) && (py12 < top12 + 12'(OBJECT_HEIGHT_Y));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inside_q <= 1'b0;
      offX_q   <= '0;
      offY_q   <= '0;
    end else begin
      inside_q <= hit;
      offX_q   <= hit ? (pix.pixelX - 11'(FINAL_X)) : 11'd0;
      offY_q   <= hit ? (pix.pixelY - topY_q) : 11'd0;
    end
  end

  assign pix.InsideRectangle = inside_q;
  assign pix.offsetX         = offX_q;
  assign pix.offsetY         = offY_q;
  assign bannerActive_o      = (state_q != IDLE);
  assign animDone_o          = (state_q == HOLD);

endmodule

// File: tb/tb_gameover_banner_ctrl.sv
// Directed bench for gameover_banner_ctrl: reset, slide, blink, hold edges,
// restart priority and one-cycle pixel latency.
module tb_gameover_banner_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic startOfFrame_i = 1'b0;
  logic gameOverTrig_i = 1'b0;
  logic restartReq_i = 1'b0;
  logic bannerActive_o, animDone_o;

  int errors = 0;
  int checks = 0;

  gameover_banner_if pix ();

  gameover_banner_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame_i (startOfFrame_i),
    .gameOverTrig_i (gameOverTrig_i),
    .restartReq_i   (restartReq_i),
    .bannerActive_o (bannerActive_o),
    .animDone_o     (animDone_o),
    .pix            (pix)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs/outputs are handled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame_i = 1'b1;
    cyc();
    startOfFrame_i = 1'b0;
    cyc();
  endtask

  task automatic probe(input string tag, input int x, input int y,
                       input int ins, input int ox, input int oy);
    pix.pixelX = 11'(x);
    pix.pixelY = 11'(y);
    cyc();
    check({tag, ".in"}, int'(pix.InsideRectangle), ins);
    check({tag, ".ox"}, int'(pix.offsetX), ox);
    check({tag, ".oy"}, int'(pix.offsetY), oy);
  endtask

  task automatic trigger();
    gameOverTrig_i = 1'b1;
    cyc();
    gameOverTrig_i = 1'b0;
  endtask

  initial begin
    pix.pixelX = 11'd300;
    pix.pixelY = 11'd10;
    #12;
    check("rst.in", int'(pix.InsideRectangle), 0);
    check("rst.act", int'(bannerActive_o), 0);
    check("rst.done", int'(animDone_o), 0);
    reset = 1'b0;
    cyc();

    // Reset in the middle of a slide
    trigger();
    check("s1.act", int'(bannerActive_o), 1);
    frame();
    frame();
    probe("s1.pre", 300, 10, 1, 50, 2);
    reset = 1'b1;
    #1;
    check("s1.rin", int'(pix.InsideRectangle), 0);
    check("s1.rox", int'(pix.offsetX), 0);
    check("s1.roy", int'(pix.offsetY), 0);
    check("s1.ract", int'(bannerActive_o), 0);
    #2;
    reset = 1'b0;
    cyc();
    probe("s1.post", 300, 10, 0, 0, 0);

    // Slide: 4 px per frame, clamped at 228 on frame 57
    trigger();
    for (int k = 1; k <= 57; k++) begin
      frame();
      if (k == 10) begin
        probe("s2.k10", 250, 40, 1, 0, 0);
        probe("s2.k10a", 250, 39, 0, 0, 0);
      end
      if (k == 20) trigger();
      if (k == 30) probe("s2.k30", 251, 120, 1, 1, 0);
      if (k == 56) begin
        probe("s2.k56", 250, 224, 1, 0, 0);
        check("s2.k56done", int'(animDone_o), 0);
      end
    end
    probe("s2.end", 250, 228, 1, 0, 0);
    probe("s2.above", 250, 227, 0, 0, 0);
    check("s2.act", int'(bannerActive_o), 1);

    // Blink: hidden 16..31, visible 32..47, ..., HOLD at 96
    for (int f = 1; f <= 96; f++) begin
      frame();
      if (f == 15) probe("b.f15", 250, 228, 1, 0, 0);
      if (f == 16) probe("b.f16", 250, 228, 0, 0, 0);
      if (f == 32) probe("b.f32", 250, 228, 1, 0, 0);
      if (f == 95) begin
        probe("b.f95", 250, 228, 0, 0, 0);
        check("b.f95done", int'(animDone_o), 0);
      end
    end
    check("b.done", int'(animDone_o), 1);
    probe("b.f96", 250, 228, 1, 0, 0);

    // Rectangle edges in HOLD
    probe("e.br", 389, 251, 1, 139, 23);
    probe("e.right", 390, 251, 0, 0, 0);
    probe("e.bottom", 389, 252, 0, 0, 0);
    probe("e.left", 249, 240, 0, 0, 0);
    frame();
    frame();
    probe("e.hold", 260, 230, 1, 10, 2);

    // Latency sweep on row 230
    pix.pixelY = 11'd230;
    for (int x = 240; x <= 400; x++) begin
      pix.pixelX = 11'(x);
      cyc();
      check("lat.in", int'(pix.InsideRectangle), (x >= 250 && x < 390) ? 1 : 0);
      check("lat.ox", int'(pix.offsetX), (x >= 250 && x < 390) ? x - 250 : 0);
    end

    // Restart has priority over trigger
    restartReq_i = 1'b1;
    gameOverTrig_i = 1'b1;
    cyc();
    restartReq_i = 1'b0;
    gameOverTrig_i = 1'b0;
    check("r.act", int'(bannerActive_o), 0);
    check("r.done", int'(animDone_o), 0);
    probe("r.hidden", 300, 230, 0, 0, 0);
    cyc();
    check("r.stay", int'(bannerActive_o), 0);
    trigger();
    check("r.act2", int'(bannerActive_o), 1);
    probe("r.top0", 300, 10, 1, 50, 10);
    probe("r.top0b", 300, 24, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
